reg_scoreboard: RTL and testbench
=================================

REG_SCOREBOARD -- requirements
Module: reg_scoreboard

Parameters
REQ-001 The block SHALL have parameter NREG, default 32, giving the number of architectural registers tracked.
REQ-002 The block SHALL have parameter MAXOUT, default 4, giving the maximum number of outstanding long-latency writes.

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port issue_valid, input, 1 bit: a long-latency op (load, mul/div) in decode requests issue.
REQ-006 The block SHALL have port issue_rd, input, 5 bits: destination register of the issuing op.
REQ-007 The block SHALL have ports rs1D and rs2D, input, 5 bits each: source registers of the instruction in decode.
REQ-008 The block SHALL have ports use_rs1D and use_rs2D, input, 1 bit each: the corresponding source is actually read.
REQ-009 The block SHALL have port wb_valid, input, 1 bit: a long-latency result is written back this cycle.
REQ-010 The block SHALL have port wb_rd, input, 5 bits: destination of that writeback.
REQ-011 The block SHALL have port stall, output, 1 bit, combinational: hold decode and fetch.
REQ-012 The block SHALL have port busy_vec, output, NREG bits, registered: pending-write bit per register.
REQ-013 The block SHALL have port outstanding, output, clog2(MAXOUT+1) bits, registered: count of set busy bits.
REQ-014 The block SHALL have port full, output, 1 bit: outstanding == MAXOUT.
REQ-015 The block SHALL have port err, output, 1 bit, registered, sticky: protocol violation seen.

Function
REQ-016 The block SHALL hold busy_vec[0] at 0 permanently; an issue or writeback with rd=0 changes no state and does not set err.
REQ-017 The block SHALL define the effective busy bits as busy_vec with bit wb_rd masked to 0 when wb_valid is 1 (same-cycle writeback bypass).
REQ-018 The block SHALL drive stall=1 when any of these hold: use_rs1D and rs1 effective-busy (RAW); use_rs2D and rs2 effective-busy (RAW); issue_valid, issue_rd!=0 and issue_rd effective-busy (WAW); issue_valid, issue_rd!=0 and full with no clearing writeback this cycle.
REQ-019 The block SHALL accept an issue when issue_valid=1 and stall=0; an accepted issue with rd!=0 sets busy_vec[rd] at the next edge.
REQ-020 The block SHALL treat a writeback as valid only when wb_valid=1, wb_rd!=0 and busy_vec[wb_rd]=1; a valid writeback clears that bit at the next edge.
REQ-021 The block SHALL, on a writeback with wb_valid=1, wb_rd!=0 and busy_vec[wb_rd]=0, leave busy_vec and outstanding unchanged and set err at the next edge.
REQ-022 The block SHALL, when a valid writeback and an accepted issue target the same rd in one cycle, leave busy_vec[rd]=1 and outstanding unchanged.
REQ-023 The block SHALL update outstanding by +1 per accepted tracked issue and -1 per valid writeback, applying both in one cycle as net 0; it SHALL never exceed MAXOUT or go below 0.
REQ-024 The block SHALL never set busy for an untracked (stalled) issue; stall asserted for an issue blocks only that issue, and writebacks continue to be processed.
REQ-025 The block SHALL give decode one-cycle visibility: a register set busy at edge N causes stall for a dependent reader from cycle N onward, and a writeback in cycle M releases a dependent reader in cycle M itself.
REQ-026 The block SHALL keep outstanding equal to popcount(busy_vec) at every edge.

Reset
REQ-027 The block SHALL, while rstn=0, immediately force busy_vec=0, outstanding=0, full=0 and err=0 regardless of clk.
REQ-028 The block SHALL drop any issue or writeback presented in the cycle rstn deasserts mid-operation; pending results that return later set err.

Verification
REQ-029 The bench SHALL check load-use: issue rd=5 in cycle 0, then rs1D=5 with use_rs1D=1 in cycle 1 -> stall=1 until a cycle with wb_valid=1, wb_rd=5, in which stall=0; busy_vec[5]=0 afterwards.
REQ-030 The bench SHALL check the x0 rule: issue rd=0, then read rs1D=0 -> stall=0, busy_vec=0, outstanding=0, err=0.
REQ-031 The bench SHALL check full: issue rd=1,2,3,4 -> outstanding=4 and full=1; issue rd=6 -> stall=1; same cycle as wb_rd=2 -> stall=0 and the issue is accepted, outstanding stays 4.
REQ-032 The bench SHALL check WAW with simultaneous events: rd=7 busy, issue rd=7 with no writeback -> stall=1; issue rd=7 together with wb_rd=7 -> stall=0, busy_vec[7]=1, outstanding unchanged.
REQ-033 The bench SHALL check the error path: wb_valid=1, wb_rd=9 while not busy -> err=1 at the next edge and stays 1; busy_vec and outstanding are unchanged.
REQ-034 The bench SHALL check asynchronous reset: with rd=3 and rd=8 busy, pulse rstn low between clock edges -> busy_vec=0, outstanding=0 and err=0 without waiting for a clock edge.

Source files
------------

// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency ops: tracks pending writes per
// architectural register, stalls decode on RAW/WAW hazards or when the
// outstanding-write budget is exhausted, and flags unmatched writebacks.
module reg_scoreboard #(
  parameter int NREG   = 32,
  parameter int MAXOUT = 4,
  localparam int OW    = $clog2(MAXOUT + 1)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      rs1D,
  input  logic [4:0]      rs2D,
  input  logic            use_rs1D,
  input  logic            use_rs2D,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  output logic            stall,
  output logic [NREG-1:0] busy_vec,
  output logic [OW-1:0]   outstanding,
  output logic            full,
  output logic            err
);

  logic [NREG-1:0] wb_mask;
  logic [NREG-1:0] eff_busy;
  logic [NREG-1:0] busy_nxt;
  logic [OW-1:0]   out_nxt;
  logic            armed;
  logic            wb_clear;
  logic            wb_bad;
  logic            accept;
  logic            issue_tracked;

  assign full = (outstanding == OW'(MAXOUT));

  // Effective busy view: a writeback landing this cycle releases its register
  // immediately so the dependent reader in decode does not lose a cycle.
  always_comb begin
    wb_mask  = '0;
    if (wb_valid) wb_mask = {{(NREG-1){1'b0}}, 1'b1} << wb_rd;
    eff_busy = busy_vec & ~wb_mask;
  end

  // Hazard detection and writeback/issue qualification. The first cycle after
  // reset release is not armed, so anything presented then is dropped.
  always_comb begin
    issue_tracked = issue_valid && (issue_rd != 5'd0);
    wb_clear      = armed && wb_valid && (wb_rd != 5'd0) && busy_vec[wb_rd];
    wb_bad        = armed && wb_valid && (wb_rd != 5'd0) && !busy_vec[wb_rd];
    stall         = (use_rs1D && eff_busy[rs1D])
                 || (use_rs2D && eff_busy[rs2D])
                 || (issue_tracked && eff_busy[issue_rd])
                 || (issue_tracked && full && !wb_clear);
    accept        = armed && issue_tracked && !stall;
  end

  // Next-state: clear first, then set, so a same-register clear+issue keeps
  // the bit busy. Register 0 is never tracked.
  always_comb begin
    busy_nxt = busy_vec;
    if (wb_clear) busy_nxt[wb_rd] = 1'b0;
    if (accept)   busy_nxt[issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
    out_nxt = outstanding;
    case ({accept, wb_clear})
      2'b10:   out_nxt = outstanding + OW'(1);
      2'b01:   out_nxt = outstanding - OW'(1);
      default: out_nxt = outstanding;
    endcase
  end

  // State registers; reset clears everything without waiting for a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed       <= 1'b0;
      busy_vec    <= '0;
      outstanding <= '0;
      err         <= 1'b0;
    end else begin
      armed       <= 1'b1;
      busy_vec    <= busy_nxt;
      outstanding <= out_nxt;
      if (wb_bad) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard: load-use, x0 rule, full,
// WAW with simultaneous writeback, error path and asynchronous reset.
module tb_reg_scoreboard;

  logic        clk;
  logic        rstn;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1D;
  logic [4:0]  rs2D;
  logic        use_rs1D;
  logic        use_rs2D;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        stall;
  logic [31:0] busy_vec;
  logic [2:0]  outstanding;
  logic        full;
  logic        err;

  int checks;
  int failures;

  reg_scoreboard #(.NREG(32), .MAXOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall(stall), .busy_vec(busy_vec), .outstanding(outstanding),
    .full(full), .err(err)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's decode/writeback inputs, then let combinational logic settle
  task automatic applyStimulus(input logic iv, input logic [4:0] ird,
                               input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic wv, input logic [4:0] wrd);
    issue_valid = iv; issue_rd = ird;
    rs1D = r1; use_rs1D = u1; rs2D = r2; use_rs2D = u2;
    wb_valid = wv; wb_rd = wrd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rstn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", busy_vec, 32'h0);
    checkOutput("reset_out", 32'(outstanding), 32'd0);
    checkOutput("reset_full", 32'(full), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_stall", 32'(stall), 32'd0);
    rstn = 1'b1;
    tick();

    // x0 rule
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_issue_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 1, 0, 0, 1, 0);
    checkOutput("x0_read_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_busy", busy_vec, 32'h0);
    checkOutput("x0_out", 32'(outstanding), 32'd0);
    checkOutput("x0_err", 32'(err), 32'd0);

    // Load-use on r5
    applyStimulus(1, 5, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_issue_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 5, 1, 0, 0, 0, 0);
    checkOutput("lu_busy5", busy_vec, 32'h20);
    checkOutput("lu_out1", 32'(outstanding), 32'd1);
    checkOutput("lu_stall_c1", 32'(stall), 32'd1);
    tick();
    checkOutput("lu_stall_c2", 32'(stall), 32'd1);
    applyStimulus(0, 0, 5, 1, 0, 0, 1, 5);
    checkOutput("lu_bypass_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("lu_busy_after", busy_vec, 32'h0);
    checkOutput("lu_out_after", 32'(outstanding), 32'd0);

    // Fill to MAXOUT
    for (int r = 1; r <= 4; r++) begin
      applyStimulus(1, 5'(r), 0, 0, 0, 0, 0, 0);
      checkOutput($sformatf("full_issue%0d_stall", r), 32'(stall), 32'd0);
      tick();
    end
    applyStimulus(1, 6, 0, 0, 0, 0, 0, 0);
    checkOutput("full_out4", 32'(outstanding), 32'd4);
    checkOutput("full_flag", 32'(full), 32'd1);
    checkOutput("full_busy", busy_vec, 32'h1E);
    checkOutput("full_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("full_stalled_untracked", busy_vec, 32'h1E);
    applyStimulus(1, 6, 0, 0, 0, 0, 1, 2);
    checkOutput("full_wb_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("full_swap_busy", busy_vec, 32'h5A);
    checkOutput("full_swap_out", 32'(outstanding), 32'd4);
    // Drain
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 1); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 6); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("drain_busy", busy_vec, 32'h0);
    checkOutput("drain_out", 32'(outstanding), 32'd0);
    checkOutput("drain_full", 32'(full), 32'd0);
    checkOutput("drain_err", 32'(err), 32'd0);

    // WAW on r7
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 7, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_stall", 32'(stall), 32'd1);
    tick();
    checkOutput("waw_busy_hold", busy_vec, 32'h80);
    checkOutput("waw_out_hold", 32'(outstanding), 32'd1);
    applyStimulus(1, 7, 0, 0, 0, 0, 1, 7);
    checkOutput("waw_wb_stall", 32'(stall), 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_busy7", busy_vec, 32'h80);
    checkOutput("waw_out", 32'(outstanding), 32'd1);
    checkOutput("waw_err", 32'(err), 32'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 7); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("waw_clear", busy_vec, 32'h0);

    // Unmatched writeback to r9
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 9);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("err_set", 32'(err), 32'd1);
    checkOutput("err_busy", busy_vec, 32'h0);
    checkOutput("err_out", 32'(outstanding), 32'd0);
    tick();
    checkOutput("err_sticky", 32'(err), 32'd1);

    // Asynchronous reset with r3 and r8 busy
    applyStimulus(1, 3, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(1, 8, 0, 0, 0, 0, 0, 0); tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ar_pre_busy", busy_vec, 32'h108);
    checkOutput("ar_pre_out", 32'(outstanding), 32'd2);
    #1 rstn = 1'b0;
    #1;
    checkOutput("ar_busy", busy_vec, 32'h0);
    checkOutput("ar_out", 32'(outstanding), 32'd0);
    checkOutput("ar_err", 32'(err), 32'd0);
    checkOutput("ar_full", 32'(full), 32'd0);
    tick();
    // Release mid-cycle with an issue presented: it must be dropped
    applyStimulus(1, 10, 0, 0, 0, 0, 0, 0);
    rstn = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ar_drop_busy", busy_vec, 32'h0);
    checkOutput("ar_drop_out", 32'(outstanding), 32'd0);
    // Stale result for r3 returns after reset
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("ar_stale_err", 32'(err), 32'd1);
    checkOutput("ar_stale_out", 32'(outstanding), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
